// File: rtl/cs_loader_if.sv
// Loader <-> EPROM / control-store RAM bus. The loader takes the slave side;
// the top level (or bench) drives ROM/RAM read data and reload from the master side.
interface cs_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
);
    logic                  reload;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram__w;
    logic                  busy;
    logic                  cs_ready;
    logic                  load_error;

    modport slave (
        input  reload, rom_data, ram_data_in,
        output rom_addr, ram_addr, ram_data_out, ram__w, busy, cs_ready, load_error
    );

    modport master (
        output reload, rom_data, ram_data_in,
        input  rom_addr, ram_addr, ram_data_out, ram__w, busy, cs_ready, load_error
    );
endinterface

// File: rtl/cs_loader.sv
// Boot-time control store loader: copies the microcode EPROM into the control store RAM.
// Define CS_LOADER_VERIFY_EN to add a read-back verify pass with an ERROR state.
module cs_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ROM_WAIT   = 1
) (
    input  logic        clk,
    input  logic        _reset,
    cs_loader_if.slave  bus
);

    localparam int WW = $clog2(ROM_WAIT + 2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ROM_WAIT - 1);

`ifdef CS_LOADER_VERIFY_EN
    localparam logic [WW-1:0] WAIT_CMP = WW'(ROM_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_VERIFY, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;
`endif

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WW-1:0]         r_wait;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ram_w;
    logic                  r_busy;
    logic                  r_ready;
    logic                  w_last;

    // Last word found by compare so the counter never has to carry out.
    assign w_last = (r_addr == {ADDR_WIDTH{1'b1}});

    assign bus.rom_addr     = r_addr;
    assign bus.ram_addr     = r_addr;
    assign bus.ram_data_out = r_data;
    assign bus.ram__w       = r_ram_w;
    assign bus.busy         = r_busy;
    assign bus.cs_ready     = r_ready;

`ifdef CS_LOADER_VERIFY_EN
    logic r_err;
    assign bus.load_error = r_err;
`else
    assign bus.load_error = 1'b0;
    wire w_unused_ram_data_in = ^bus.ram_data_in;
`endif

    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wait  <= '0;
            r_data  <= '0;
            r_ram_w <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
`ifdef CS_LOADER_VERIFY_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_READ;
                    r_busy  <= 1'b1;
                    r_wait  <= '0;
                end
                // rom_data is captured on the edge that ends the ROM wait,
                // so it is already stable throughout SETUP.
                S_READ: begin
                    if (r_wait == WAIT_LAST) begin
                        r_data  <= bus.rom_data;
                        r_state <= S_SETUP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_SETUP: begin
                    r_ram_w <= 1'b0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    r_ram_w <= 1'b1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    r_wait <= '0;
                    if (w_last) begin
                        r_addr  <= '0;
`ifdef CS_LOADER_VERIFY_EN
                        r_state <= S_VERIFY;
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
`endif
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_DONE: begin
                    if (bus.reload) begin
                        r_state <= S_READ;
                        r_addr  <= '0;
                        r_wait  <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
`ifdef CS_LOADER_VERIFY_EN
                // ROM_WAIT settle cycles, then one compare cycle per word.
                S_VERIFY: begin
                    if (r_wait != WAIT_CMP) begin
                        r_wait <= r_wait + 1'b1;
                    end else if (bus.ram_data_in != bus.rom_data) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        r_addr  <= '0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        r_wait <= '0;
                    end
                end
                S_ERROR: begin
                    if (bus.reload) begin
                        r_state <= S_READ;
                        r_addr  <= '0;
                        r_wait  <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_ram_w <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
